// File: rtl/port_wr_packet_sender.sv
// Per-port ingress transmitter: buffers pushed packet words and replays them
// onto the switch write protocol (sop / vld+data / eop) at packet boundaries.
module port_wr_packet_sender #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_vld,
  input  logic [15:0]   push_data,
  input  logic          push_last,
  output logic          push_rdy,
  input  logic          pause,
  input  logic          full,
  output logic          wr_sop,
  output logic          wr_vld,
  output logic [15:0]   wr_data,
  output logic          wr_eop,
  output logic          len_err,
  output logic [AW:0]   pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SOP,
    DATA,
    EOP
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [16:0]   mem [DEPTH];
  logic [16:0]   rdata;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   pkt_cnt_q, pkt_cnt_d;
  logic [8:0]    plen_q, plen_d;
  logic [8:0]    hlen_q, hlen_d;
  logic          cur_last_q, cur_last_d;
  logic          push, pop;

  logic          push_rdy_q;
  logic          wr_sop_q, wr_vld_q, wr_eop_q, len_err_q;
  logic [15:0]   wr_data_q;

  assign push  = push_vld && push_rdy_q;
  assign rdata = mem[rd_ptr_q];

  // A pop is the edge that loads the word onto wr_data, so the
  // word shown in DATA is already gone from the buffer.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    plen_d     = plen_q;
    hlen_d     = hlen_q;
    cur_last_d = cur_last_q;
    unique case (state_q)
      IDLE: begin
        if (pkt_cnt_q != '0 && !pause && !full)
          state_d = SOP;
      end
      SOP: begin
        pop        = 1'b1;
        plen_d     = '0;
        hlen_d     = rdata[15:7];
        cur_last_d = rdata[16];
        state_d    = DATA;
      end
      DATA: begin
        if (cur_last_q) begin
          state_d = EOP;
        end else begin
          pop        = 1'b1;
          plen_d     = plen_q + 9'd1;
          cur_last_d = rdata[16];
        end
      end
      EOP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    pkt_cnt_d = pkt_cnt_q
              + (AW+1)'(push && push_last)
              - (AW+1)'(pop && rdata[16]);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q] <= {push_last, push_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      plen_q     <= '0;
      hlen_q     <= '0;
      cur_last_q <= 1'b0;
      push_rdy_q <= 1'b1;
      wr_sop_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      len_err_q  <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      pkt_cnt_q  <= pkt_cnt_d;
      plen_q     <= plen_d;
      hlen_q     <= hlen_d;
      cur_last_q <= cur_last_d;
      push_rdy_q <= (count_d != FULL_CNT);
      wr_sop_q   <= (state_d == SOP);
      wr_vld_q   <= pop;
      wr_eop_q   <= (state_d == EOP);
      len_err_q  <= (state_d == EOP) && (plen_q != hlen_q);
      wr_data_q  <= pop ? rdata[15:0] : 16'h0000;
    end
  end

  assign push_rdy = push_rdy_q;
  assign wr_sop   = wr_sop_q;
  assign wr_vld   = wr_vld_q;
  assign wr_data  = wr_data_q;
  assign wr_eop   = wr_eop_q;
  assign len_err  = len_err_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule
